game_flow_ctrl: RTL

Parametrised game-flow sequencer that replaces the ad-hoc opening-screen counter and the standalone lives counter. It owns the title screen, the delay before each asteroid wave, the respawn delay, the level count, the lives count and game over. It sits beside the asteroid/ship units, is clocked at 25 MHz, and all of its timing is counted in frames using the VGA vsync pulse.

---
 rtl/game_flow_ctrl_pkg.sv | 23 ++
 rtl/game_flow_ctrl_if.sv | 35 +++
 rtl/game_flow_ctrl_frame_timer.sv | 40 ++++
 rtl/game_flow_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/game_flow_ctrl_pkg.sv
// Shared types for the asteroids game-flow slice: game state encoding,
// frame-timer width and the title zoom helper.
package asteroids;

    localparam int FRAME_TMR_W = 10;

    typedef enum logic [2:0] {
        TITLE      = 3'd0,
        WAVE_DELAY = 3'd1,
        PLAY       = 3'd2,
        RESPAWN    = 3'd3,
        GAME_OVER  = 3'd4
    } game_state_t;

    // Stretch the elapsed title frame count onto the full 8-bit zoom range.
    function automatic logic [7:0] title_ramp(input logic [FRAME_TMR_W-1:0] elapsed,
                                              input int unsigned            shift);
        logic [FRAME_TMR_W-1:0] wide;
        wide = elapsed << shift;
        return wide[7:0];
    endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Game-flow signal bundle between the playfield logic (master) and the
// game_flow_ctrl sequencer (slave).
interface game_flow_ctrl_if #(
    parameter int LIVES_W = 4,
    parameter int LEVEL_W = 4
);
    import asteroids::*;

    logic               vsync_pulse;
    logic               start_btn;
    logic               die;
    logic               bonus;
    logic               wave_cleared;
    game_state_t        state;
    logic               title_draw;
    logic [7:0]         title_scale;
    logic               game_begin;
    logic               game_continue;
    logic               new_level;
    logic               game_over;
    logic [LIVES_W-1:0] lives;
    logic [LEVEL_W-1:0] level;

    modport master (
        output vsync_pulse, start_btn, die, bonus, wave_cleared,
        input  state, title_draw, title_scale, game_begin, game_continue,
               new_level, game_over, lives, level
    );

    modport slave (
        input  vsync_pulse, start_btn, die, bonus, wave_cleared,
        output state, title_draw, title_scale, game_begin, game_continue,
               new_level, game_over, lives, level
    );
endinterface

// File: rtl/game_flow_ctrl_frame_timer.sv
// Loadable frame down-counter shared by every timed game state. It expires
// on a tick while at zero; a load in the same cycle takes priority.
module frame_timer
    import asteroids::*;
#(
    parameter logic [FRAME_TMR_W-1:0] RST_VAL = {FRAME_TMR_W{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   load,
    input  logic [FRAME_TMR_W-1:0] load_val,
    output logic [FRAME_TMR_W-1:0] count_nx,
    output logic                   expired
);
    logic [FRAME_TMR_W-1:0] count_r;

    assign expired = tick && (count_r == {FRAME_TMR_W{1'b0}});

    // Next count: reload wins, otherwise step down on each frame tick until zero.
    always_comb begin
        count_nx = count_r;
        if (load) begin
            count_nx = load_val;
        end else if (tick && (count_r != {FRAME_TMR_W{1'b0}})) begin
            count_nx = count_r - {{(FRAME_TMR_W-1){1'b0}}, 1'b1};
        end else begin
            count_nx = count_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= RST_VAL;
        end else begin
            count_r <= count_nx;
        end
    end
endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: title screen, wave delay, play, respawn and game over,
// with lives and level bookkeeping. All timing is counted in vsync frames.
// Optional attract loop (GAME_OVER times out back to TITLE): GAME_FLOW_GO_TIMEOUT_EN.
module game_flow_ctrl
    import asteroids::*;
#(
    parameter int NUM_LIVES         = 3,
    parameter int MAX_NUM_LIVES     = 10,
    parameter int TITLE_FRAMES      = 256,
    parameter int WAVE_DELAY_FRAMES = 128,
    parameter int RESPAWN_FRAMES    = 120,
    parameter int LEVEL_W           = 4,
    parameter int GO_TIMEOUT_FRAMES = 600
) (
    input  logic             clk,
    input  logic             rst,
    game_flow_ctrl_if.slave  gf
);
    localparam int LIVES_W  = $clog2(MAX_NUM_LIVES + 1);
    localparam int SCALE_SH = 8 - $clog2(TITLE_FRAMES);

    localparam logic [LIVES_W-1:0]     LIVES_INIT   = LIVES_W'(NUM_LIVES);
    localparam logic [LIVES_W-1:0]     LIVES_MAX    = LIVES_W'(MAX_NUM_LIVES);
    localparam logic [LIVES_W-1:0]     LIVES_ONE    = LIVES_W'(1);
    localparam logic [LEVEL_W-1:0]     LEVEL_MAX    = {LEVEL_W{1'b1}};
    localparam logic [LEVEL_W-1:0]     LEVEL_ONE    = LEVEL_W'(1);
    localparam logic [FRAME_TMR_W-1:0] TMR_ZERO     = {FRAME_TMR_W{1'b0}};
    localparam logic [FRAME_TMR_W-1:0] TITLE_LOAD   = FRAME_TMR_W'(TITLE_FRAMES - 1);
    localparam logic [FRAME_TMR_W-1:0] WAVE_LOAD    = FRAME_TMR_W'(WAVE_DELAY_FRAMES - 1);
    localparam logic [FRAME_TMR_W-1:0] RESPAWN_LOAD = FRAME_TMR_W'(RESPAWN_FRAMES - 1);
`ifdef GAME_FLOW_GO_TIMEOUT_EN
    localparam logic [FRAME_TMR_W-1:0] GO_LOAD      = FRAME_TMR_W'(GO_TIMEOUT_FRAMES - 1);
`endif

    game_state_t            state_r, state_nx_s;
    logic [LIVES_W-1:0]     lives_r, lives_nx_s, lives_up_s;
    logic [LEVEL_W-1:0]     level_r, level_nx_s, level_up_s;
    logic                   wc_pend_r, wc_pend_nx_s, wc_eff_s;
    logic                   start_d_r, start_rise_s;
    logic                   tmr_load_s, tmr_expired_s;
    logic [FRAME_TMR_W-1:0] tmr_val_s, tmr_cnt_nx_s;
    logic                   new_level_r, new_level_nx_s;
    logic                   title_draw_r, title_draw_nx_s;
    logic [7:0]             title_scale_r, title_scale_nx_s;
    logic                   game_begin_r, game_begin_nx_s;
    logic                   game_continue_r, game_continue_nx_s;
    logic                   game_over_r, game_over_nx_s;

    assign lives_up_s   = (lives_r == LIVES_MAX) ? lives_r : (lives_r + LIVES_ONE);
    assign level_up_s   = (level_r == LEVEL_MAX) ? level_r : (level_r + LEVEL_ONE);
    assign wc_eff_s     = gf.wave_cleared || wc_pend_r;
    assign start_rise_s = gf.start_btn && !start_d_r;

    frame_timer #(.RST_VAL(TITLE_LOAD)) u_frame_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (gf.vsync_pulse),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .count_nx (tmr_cnt_nx_s),
        .expired  (tmr_expired_s)
    );

    // Next-state, lives, level and timer reload decisions.
    always_comb begin
        state_nx_s     = state_r;
        lives_nx_s     = lives_r;
        level_nx_s     = level_r;
        wc_pend_nx_s   = wc_pend_r;
        tmr_load_s     = 1'b0;
        tmr_val_s      = TMR_ZERO;
        new_level_nx_s = 1'b0;
        case (state_r)
            TITLE: begin
                if (tmr_expired_s) begin
                    state_nx_s = WAVE_DELAY;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = WAVE_LOAD;
                end else begin
                    state_nx_s = TITLE;
                end
            end
            WAVE_DELAY: begin
                if (tmr_expired_s) begin
                    state_nx_s     = PLAY;
                    tmr_load_s     = 1'b1;
                    new_level_nx_s = 1'b1;
                end else begin
                    state_nx_s = WAVE_DELAY;
                end
            end
            PLAY: begin
                if (gf.die) begin
                    // A simultaneous bonus cancels the lost life, so the ship always respawns.
                    tmr_load_s = 1'b1;
                    if (gf.bonus || (lives_r > LIVES_ONE)) begin
                        state_nx_s = RESPAWN;
                        tmr_val_s  = RESPAWN_LOAD;
                        lives_nx_s = gf.bonus ? lives_r : (lives_r - LIVES_ONE);
                    end else begin
                        state_nx_s   = GAME_OVER;
                        lives_nx_s   = {LIVES_W{1'b0}};
                        wc_pend_nx_s = 1'b0;
`ifdef GAME_FLOW_GO_TIMEOUT_EN
                        tmr_val_s    = GO_LOAD;
`else
                        tmr_val_s    = TMR_ZERO;
`endif
                    end
                end else if (wc_eff_s) begin
                    state_nx_s   = WAVE_DELAY;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = WAVE_LOAD;
                    level_nx_s   = level_up_s;
                    wc_pend_nx_s = 1'b0;
                    lives_nx_s   = gf.bonus ? lives_up_s : lives_r;
                end else begin
                    lives_nx_s = gf.bonus ? lives_up_s : lives_r;
                end
            end
            RESPAWN: begin
                lives_nx_s   = gf.bonus ? lives_up_s : lives_r;
                wc_pend_nx_s = wc_pend_r || gf.wave_cleared;
                if (tmr_expired_s) begin
                    state_nx_s = PLAY;
                    tmr_load_s = 1'b1;
                end else begin
                    state_nx_s = RESPAWN;
                end
            end
            GAME_OVER: begin
`ifdef GAME_FLOW_GO_TIMEOUT_EN
                if (start_rise_s || tmr_expired_s) begin
`else
                if (start_rise_s) begin
`endif
                    state_nx_s   = TITLE;
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = TITLE_LOAD;
                    lives_nx_s   = LIVES_INIT;
                    level_nx_s   = {LEVEL_W{1'b0}};
                    wc_pend_nx_s = 1'b0;
                end else begin
                    state_nx_s = GAME_OVER;
                end
            end
            default: begin
                state_nx_s   = TITLE;
                tmr_load_s   = 1'b1;
                tmr_val_s    = TITLE_LOAD;
                lives_nx_s   = LIVES_INIT;
                level_nx_s   = {LEVEL_W{1'b0}};
                wc_pend_nx_s = 1'b0;
            end
        endcase
    end

    // Output values decoded from the upcoming state, registered below.
    always_comb begin
        title_draw_nx_s    = (state_nx_s == TITLE);
        game_begin_nx_s    = (state_nx_s == PLAY) || (state_nx_s == RESPAWN);
        game_continue_nx_s = (state_nx_s == PLAY);
        game_over_nx_s     = (state_nx_s == GAME_OVER);
        if (state_nx_s == TITLE) begin
            title_scale_nx_s = title_ramp(TITLE_LOAD - tmr_cnt_nx_s, SCALE_SH);
        end else begin
            title_scale_nx_s = 8'd0;
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= TITLE;
            lives_r         <= LIVES_INIT;
            level_r         <= {LEVEL_W{1'b0}};
            wc_pend_r       <= 1'b0;
            start_d_r       <= 1'b0;
            new_level_r     <= 1'b0;
            title_draw_r    <= 1'b1;
            title_scale_r   <= 8'd0;
            game_begin_r    <= 1'b0;
            game_continue_r <= 1'b0;
            game_over_r     <= 1'b0;
        end else begin
            state_r         <= state_nx_s;
            lives_r         <= lives_nx_s;
            level_r         <= level_nx_s;
            wc_pend_r       <= wc_pend_nx_s;
            start_d_r       <= gf.start_btn;
            new_level_r     <= new_level_nx_s;
            title_draw_r    <= title_draw_nx_s;
            title_scale_r   <= title_scale_nx_s;
            game_begin_r    <= game_begin_nx_s;
            game_continue_r <= game_continue_nx_s;
            game_over_r     <= game_over_nx_s;
        end
    end

    assign gf.state         = state_r;
    assign gf.lives         = lives_r;
    assign gf.level         = level_r;
    assign gf.new_level     = new_level_r;
    assign gf.title_draw    = title_draw_r;
    assign gf.title_scale   = title_scale_r;
    assign gf.game_begin    = game_begin_r;
    assign gf.game_continue = game_continue_r;
    assign gf.game_over     = game_over_r;
endmodule
